// File: rtl/ram_word_initiator.sv
// ram_word_initiator
// Bridges a word-wide valid/ready requester onto a single-port, byte-wide RAM.
// Each BYTES-wide request is split into BYTES sequential byte accesses. Read bytes
// are reassembled little-endian, and each request gets exactly one response.
// Misaligned requests are answered with rsp_err and never touch the RAM.
module ram_word_initiator #(
    parameter int ADDRWIDTH = 20,
    parameter int BYTES     = 4
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDRWIDTH-1:0]   req_addr,
    input  logic [8*BYTES-1:0]     req_wdata,
    input  logic [BYTES-1:0]       req_be,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [8*BYTES-1:0]     rsp_rdata,
    output logic                   rsp_err,
    output logic [ADDRWIDTH-1:0]   ram_addr,
    output logic [7:0]             ram_wdata,
    output logic                   ram_we,
    input  logic [7:0]             ram_rdata
);

    localparam int W  = 8 * BYTES;
    localparam int CW = $clog2(BYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDTAIL,
        S_RSP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [ADDRWIDTH-1:0]   base_q, base_d;
    logic [W-1:0]           wdata_q, wdata_d;
    logic [BYTES-1:0]       be_q, be_d;
    logic [W-1:0]           rdata_q, rdata_d;
    logic                   err_q, err_d;

    logic                   misaligned;
    logic [CW-1:0]          prev_idx;
    logic [7:0]             wbyte_sel;
    logic                   be_sel;

    // Any set bit below the word boundary makes the request misaligned.
    assign misaligned = |req_addr[CW-1:0];

    // Byte returned by the RAM this cycle belongs to the address issued last cycle.
    assign prev_idx = cnt_q - 1'b1;

    // Select the write byte and its enable for the current byte slot.
    always_comb begin
        wbyte_sel = 8'h00;
        be_sel    = 1'b0;
        for (int i = 0; i < BYTES; i++) begin
            if (cnt_q == CW'(i)) begin
                wbyte_sel = wdata_q[8*i +: 8];
                be_sel    = be_q[i];
            end
        end
    end

    // Next-state and datapath update for the request/byte-sequencing FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    base_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    rdata_d = '0;
                    cnt_d   = '0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_RSP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = req_write ? S_WR : S_RD;
                    end
                end
            end
            S_WR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RSP;
                end
            end
            S_RD: begin
                cnt_d = cnt_q + 1'b1;
                // Slot 0 has no data yet; later slots capture the previous byte.
                if (cnt_q != '0) begin
                    for (int i = 0; i < BYTES; i++) begin
                        if (prev_idx == CW'(i)) begin
                            rdata_d[8*i +: 8] = ram_rdata;
                        end
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = S_RDTAIL;
                end
            end
            S_RDTAIL: begin
                rdata_d[W-1 -: 8] = ram_rdata;
                state_d           = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and everything that reaches an output; cleared by reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Latched write payload; only meaningful after an accept, so no reset needed.
    always_ff @(posedge clk) begin
        wdata_q <= wdata_d;
        be_q    <= be_d;
    end

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    // Alignment guarantees no carry out of the counter bits, so a word never wraps.
    assign ram_addr  = base_q + ADDRWIDTH'(cnt_q);
    assign ram_we    = (state_q == S_WR) && be_sel;
    assign ram_wdata = (state_q == S_WR) ? wbyte_sel : 8'h00;

endmodule

// File: tb/tb_ram_word_initiator.sv
// Testbench for ram_word_initiator: byte RAM model, shadow memory and response scoreboard.
module tb_ram_word_initiator;

    localparam int AW = 20;
    localparam int NB = 4;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [31:0]     req_wdata = '0;
    logic [3:0]      req_be = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [AW-1:0]   ram_addr;
    logic [7:0]      ram_wdata;
    logic            ram_we;
    logic [7:0]      ram_rdata = 8'h00;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t       sb[$];
    logic [7:0] shadow [int];
    logic [7:0] ram_mem [0:(1<<AW)-1] = '{default: 8'h00};

    always #5 clk = ~clk;

    ram_word_initiator #(.ADDRWIDTH(AW), .BYTES(NB)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    // Synchronous byte RAM: registered read of the old contents, write on ram_we.
    always @(posedge clk) begin
        ram_rdata <= ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
    end

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sh_rd(input logic [AW-1:0] a);
        return shadow.exists(int'(a)) ? shadow[int'(a)] : 8'h00;
    endfunction

    // Issue one request, check RAM traffic, latency and the scoreboarded response.
    task automatic run_req(input string tag, input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [3:0] be, input int stall);
        rsp_t          exp_r;
        logic [27:0]   exp_w[$];
        logic [27:0]   wlog[$];
        logic [AW-1:0] alog[$];
        logic [AW-1:0] a;
        int            lat;
        int            exp_lat;
        logic          err;

        err         = (addr[1:0] != 2'b00);
        exp_r.err   = err;
        exp_r.rdata = '0;
        if (!err) begin
            for (int i = 0; i < NB; i++) begin
                a = addr + AW'(i);
                if (wr) begin
                    if (be[i]) begin
                        shadow[int'(a)] = wd[8*i +: 8];
                        exp_w.push_back({a, wd[8*i +: 8]});
                    end
                end else begin
                    exp_r.rdata[8*i +: 8] = sh_rd(a);
                end
            end
        end
        // Posedges after the accept edge before rsp_valid is visible.
        exp_lat = err ? 0 : (wr ? NB : NB + 1);
        sb.push_back(exp_r);

        chk_eq({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        rsp_ready = (stall == 0);
        @(negedge clk);
        if (stall == 0) begin
            req_valid = 1'b0;
        end else begin
            req_addr  = addr ^ AW'('h40);
            req_write = ~wr;
        end

        lat = 0;
        while (!rsp_valid && lat < 20) begin
            alog.push_back(ram_addr);
            if (ram_we) wlog.push_back({ram_addr, ram_wdata});
            @(negedge clk);
            lat++;
        end
        chk_eq({tag, "_rsp_seen"}, rsp_valid, 1);
        chk_eq({tag, "_latency"}, lat, exp_lat);

        exp_r = sb.pop_front();
        chk_eq({tag, "_rdata"}, rsp_rdata, exp_r.rdata);
        chk_eq({tag, "_err"}, rsp_err, exp_r.err);
        chk_eq({tag, "_nwrites"}, wlog.size(), exp_w.size());
        for (int i = 0; i < exp_w.size(); i++) begin
            chk_eq({tag, "_wbyte"}, (i < wlog.size()) ? 64'(wlog[i]) : 64'hBAD0_0000_0000, 64'(exp_w[i]));
        end
        if (!err && !wr) begin
            for (int i = 0; i < NB; i++) begin
                chk_eq({tag, "_raddr"}, (i < alog.size()) ? 64'(alog[i]) : 64'hBAD0_0000_0000,
                       64'(addr + AW'(i)));
            end
        end

        for (int c = 0; c < stall; c++) begin
            @(negedge clk);
            chk_eq({tag, "_hold_valid"}, rsp_valid, 1);
            chk_eq({tag, "_hold_rdata"}, rsp_rdata, exp_r.rdata);
            chk_eq({tag, "_hold_err"}, rsp_err, exp_r.err);
            chk_eq({tag, "_hold_ready"}, req_ready, 0);
        end

        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk_eq({tag, "_rsp_done"}, rsp_valid, 0);
        chk_eq({tag, "_back_idle"}, req_ready, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_req_ready"}, req_ready, 1);
        chk_eq({tag, "_rsp_valid"}, rsp_valid, 0);
        chk_eq({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk_eq({tag, "_rsp_err"}, rsp_err, 0);
        chk_eq({tag, "_ram_addr"}, ram_addr, 0);
        chk_eq({tag, "_ram_wdata"}, ram_wdata, 0);
        chk_eq({tag, "_ram_we"}, ram_we, 0);
    endtask

    initial begin
        int spur;
        logic [AW-1:0] ra;
        logic          rw;

        repeat (3) @(negedge clk);
        chk_reset_outputs("por");
        rst_b = 1'b1;
        @(negedge clk);

        // Full write then read back.
        run_req("wr_full", 1'b1, 20'h01000, 32'hDEADBEEF, 4'hF, 0);
        run_req("rd_full", 1'b0, 20'h01000, 32'h0, 4'h0, 0);

        // Partial byte-enable write over existing data.
        run_req("wr_be5", 1'b1, 20'h01000, 32'h11223344, 4'b0101, 0);
        run_req("rd_be5", 1'b0, 20'h01000, 32'h0, 4'h0, 0);
        chk_eq("rd_be5_model", {sh_rd(20'h01003), sh_rd(20'h01002), sh_rd(20'h01001), sh_rd(20'h01000)},
               32'hDE22BE44);

        // Misaligned read and write: error response, no RAM writes.
        run_req("rd_misal", 1'b0, 20'h01002, 32'h0, 4'h0, 0);
        run_req("wr_misal", 1'b1, 20'h01001, 32'h55555555, 4'hF, 0);
        run_req("rd_after_misal", 1'b0, 20'h01000, 32'h0, 4'h0, 0);

        // Response backpressure with a competing request held valid.
        run_req("rd_stall", 1'b0, 20'h01000, 32'h0, 4'h0, 10);

        // Reset in the middle of a write: two bytes land, no response.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 20'h02000;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'hF;
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk_reset_outputs("abort");
        shadow[32'h2000] = 8'h0D;
        shadow[32'h2001] = 8'hF0;
        @(negedge clk);
        rst_b = 1'b1;
        spur = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) spur++;
        end
        chk_eq("abort_no_rsp", spur, 0);
        run_req("rd_abort", 1'b0, 20'h02000, 32'h0, 4'h0, 0);

        // Top of the address space: no wrap within the word.
        run_req("wr_top", 1'b1, 20'hFFFFC, 32'hA5C37E19, 4'hF, 0);
        run_req("rd_top", 1'b0, 20'hFFFFC, 32'h0, 4'h0, 0);
        run_req("rd_zero", 1'b0, 20'h00000, 32'h0, 4'h0, 0);

        // Random mix in a small window, occasionally misaligned.
        for (int n = 0; n < 16; n++) begin
            ra = 20'h03000 + AW'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 7) == 0) ra = ra + AW'($urandom_range(1, 3));
            rw = 1'($urandom_range(0, 1));
            run_req("rnd", rw, ra, $urandom, 4'($urandom_range(0, 15)), 0);
        end

        chk_eq("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
